// File: rtl/i2s_rx.sv
// i2s_rx: oversampled Philips-I2S receiver delivering one stereo pair per frame
module i2s_rx #(
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_adc_bck,
  input  logic                    i_adc_lrck,
  input  logic                    i_adc_adata,
  output logic [SAMPLE_WIDTH-1:0] o_left,
  output logic [SAMPLE_WIDTH-1:0] o_right,
  output logic                    o_valid,
  output logic                    o_frame_err
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  logic [2:0] bck_s;
  logic [1:0] lr_s, d_s;
  logic [1:0] ev_q, l_q, d_q;
  logic [SAMPLE_WIDTH-1:0] shreg, left_hold, shreg_sh;
  logic [CW-1:0] bit_cnt, cnt_sh;
  logic left_ok, synced, lrck_prev;
  logic rise, ev, l, d, full, bnd, done, close_l, close_r, short_slot;
  // bck rises are detected one stage behind the synchronizer so lrck/adata sync2 line up with the strobe
  assign rise = bck_s[1] & ~bck_s[2];
  assign ev = ev_q[1];
  assign l = l_q[1];
  assign d = d_q[1];
  // shift/count update, then slot-close decisions evaluated on the post-shift count
  always_comb begin
    full = bit_cnt == CW'(SAMPLE_WIDTH);
    shreg_sh = full ? shreg : {shreg[SAMPLE_WIDTH-2:0], d};
    cnt_sh = full ? bit_cnt : bit_cnt + 1'b1;
    bnd = ev & (l != lrck_prev);
    done = cnt_sh == CW'(SAMPLE_WIDTH);
    close_l = bnd & synced & done & ~lrck_prev;
    close_r = bnd & synced & done & lrck_prev & left_ok;
    short_slot = bnd & synced & ~done;
  end
  // synchronizers plus a two-deep event pipeline that sets the strobe latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bck_s <= '0;
      lr_s <= '0;
      d_s <= '0;
      ev_q <= '0;
      l_q <= '0;
      d_q <= '0;
    end else begin
      bck_s <= {bck_s[1:0], i_adc_bck};
      lr_s <= {lr_s[0], i_adc_lrck};
      d_s <= {d_s[0], i_adc_adata};
      ev_q <= {ev_q[0], rise};
      l_q <= {l_q[0], rise ? lr_s[1] : l_q[0]};
      d_q <= {d_q[0], rise ? d_s[1] : d_q[0]};
    end
  end
  // deserializer state and slot bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      bit_cnt <= '0;
      left_hold <= '0;
      left_ok <= 1'b0;
      synced <= 1'b0;
      lrck_prev <= 1'b0;
    end else if (ev) begin
      shreg <= bnd ? '0 : shreg_sh;
      bit_cnt <= bnd ? '0 : cnt_sh;
      synced <= synced | bnd;
      lrck_prev <= l;
      left_hold <= close_l ? shreg_sh : left_hold;
      left_ok <= close_l | (left_ok & ~close_r & ~short_slot);
    end
  end
  // output registers: stereo pair loads only when a right slot completes a good frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_left <= '0;
      o_right <= '0;
      o_valid <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid <= close_r;
      o_frame_err <= short_slot;
      o_left <= close_r ? left_hold : o_left;
      o_right <= close_r ? shreg_sh : o_right;
    end
  end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed I2S frames with a queue-based scoreboard and decoupled monitor
module tb_i2s_rx;
  localparam int SW = 24;
  logic clk = 0, rst_n = 0, bck = 0, lrck = 0, adata = 0;
  logic [SW-1:0] o_left, o_right;
  logic o_valid, o_frame_err;
  i2s_rx #(.SAMPLE_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .i_adc_bck(bck), .i_adc_lrck(lrck), .i_adc_adata(adata),
    .o_left(o_left), .o_right(o_right), .o_valid(o_valid), .o_frame_err(o_frame_err)
  );
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0, n_err = 0, exp_err = 0, bnd_cyc = -100;
  logic [2*SW-1:0] exp_q[$];
  logic [2*SW-1:0] prev = '0;
  logic [2*SW-1:0] e;
  bit dly = 0, lr_prev = 0, done = 0, fin = 0;
  int ph = 3;
  // one bck period; adata lags lrck by one bit to model the I2S one-bit delay
  task automatic bit_out(input bit lv, input bit dv);
    @(negedge clk);
    bck = 0; lrck = lv; adata = dly; dly = dv;
    repeat (ph) @(negedge clk);
    bck = 1;
    if (lv != lr_prev) bnd_cyc = cyc;
    lr_prev = lv;
    repeat (ph - 1) @(negedge clk);
  endtask
  task automatic slot(input bit lv, input logic [SW-1:0] s, input int n);
    logic [SW-1:0] sr;
    sr = s;
    for (int i = 0; i < n; i++) begin
      bit_out(lv, i < SW ? sr[SW-1] : 1'b1);
      sr = sr << 1;
    end
  endtask
  task automatic frame(input logic [SW-1:0] a, input logic [SW-1:0] b, input int n, input bit ex);
    if (ex) exp_q.push_back({a, b});
    slot(0, a, n);
    slot(1, b, n);
  endtask
  // monitor: pops the scoreboard on every o_valid and checks strobe timing and hold behaviour
  always @(negedge clk) begin
    if (!rst_n) begin
      n_chk++;
      if ({o_left, o_right, o_valid, o_frame_err} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h %h v=%b e=%b want all zero", o_left, o_right, o_valid, o_frame_err);
      end
    end else begin
      if (o_valid && o_frame_err) begin
        n_chk++; n_fail++;
        $display("FAIL strobe_overlap: got valid=1 err=1 want not both");
      end
      if (o_valid) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL valid_unexpected: got %h/%h want no valid", o_left, o_right);
        end else begin
          e = exp_q.pop_front();
          if ({o_left, o_right} !== e || cyc != bnd_cyc + 5) begin
            n_fail++;
            $display("FAIL valid_data: got %h/%h at +%0d want %h/%h at +5", o_left, o_right, cyc - bnd_cyc, e[2*SW-1:SW], e[SW-1:0]);
          end
        end
      end else begin
        n_chk++;
        if ({o_left, o_right} !== prev) begin
          n_fail++;
          $display("FAIL hold: got %h want %h", {o_left, o_right}, prev);
        end
      end
      if (o_frame_err) begin
        n_chk++; n_err++;
        if (cyc != bnd_cyc + 5) begin
          n_fail++;
          $display("FAIL err_latency: got +%0d want +5", cyc - bnd_cyc);
        end
      end
    end
    prev = {o_left, o_right};
    if (done && !fin) begin
      n_chk += 2;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_valid: got %0d pending want 0", exp_q.size());
      end
      if (n_err != exp_err) begin
        n_fail++;
        $display("FAIL err_count: got %0d want %0d", n_err, exp_err);
      end
      fin = 1;
    end
  end
  initial begin
    #3ms;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] r1, r2;
    fork
      frame(24'h111111, 24'h222222, 32, 0);
      begin
        wait (lrck == 1);
        repeat (40) @(posedge clk);
        #1 rst_n = 1;
      end
    join
    frame(24'hABCDEF, 24'h123456, 32, 1);
    frame(24'h5A5A5A, 24'hA5A5A5, 32, 1);
    frame(24'h800001, 24'h7FFFFE, 24, 1);
    for (int i = 0; i < 64; i++) begin
      r1 = $urandom; r2 = $urandom;
      frame(r1[SW-1:0], r2[SW-1:0], 24, 1);
    end
    slot(0, 24'hFFFF00, 16);
    exp_err++;
    slot(1, 24'h333333, 24);
    frame(24'h0F0F0F, 24'hF0F0F0, 24, 1);
    frame(24'h246802, 24'h135791, 24, 1);
    fork
      slot(0, 24'hDEAD00, 24);
      begin
        repeat (70) @(posedge clk);
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
      end
    join
    slot(1, 24'hBEEF00, 24);
    frame(24'hC0FFEE, 24'h00BEEF, 24, 1);
    for (int i = 0; i < 160; i++) frame(SW'(i), SW'(~i), 24, 1);
    slot(0, 24'h000000, 4);
    repeat (20) @(negedge clk);
    done = 1;
    wait (fin);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
